fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly downstream of the branch unit; consumes its NextPCSrc decision as a redirect request together with the computed target address.
- Owns the PC register and issues one-outstanding fetch requests to instruction memory over a valid/ready handshake.
- Buffers one returned instruction and hands it to decode over a valid/ready handshake.
- Discards wrong-path requests and instructions on redirect.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage: one outstanding imem request,
// a single-entry instruction buffer toward decode, wrong-path squashing.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] BranchTarget,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_valid;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [XLEN-1:0] r_inst_pc4;
  logic [31:0]     r_count;

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_tgt;
  logic            w_acc;
  logic            w_fire;

  assign w_pc4  = r_pc + XLEN'(4);
  assign w_tgt  = BranchTarget & ~XLEN'(3);
  assign w_acc  = r_req_valid & imem_req_ready;
  assign w_fire = r_inst_valid & inst_ready & ~NextPCSrc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_pc4   <= '0;
      r_count      <= '0;
    end else begin
      if (NextPCSrc)
        r_pc <= w_tgt;
      else if (w_fire)
        r_pc <= w_pc4;

      unique case (r_state)
        S_REQ: begin
          // valid rises one edge after reset release, then holds until accepted
          r_req_valid <= 1'b1;
          if (w_acc) begin
            r_req_valid <= 1'b0;
            r_state     <= NextPCSrc ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (NextPCSrc) begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state      <= S_HOLD;
              r_inst_valid <= 1'b1;
              r_inst       <= imem_rsp_data;
              r_inst_pc    <= r_pc;
              r_inst_pc4   <= w_pc4;
            end
          end else if (NextPCSrc) begin
            r_state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (NextPCSrc || w_fire) begin
            r_state      <= S_REQ;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
          if (w_fire)
            r_count <= r_count + 32'd1;
        end
        S_DROP: begin
          // the squashed response retires the outstanding request
          if (imem_rsp_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_pc4       = r_inst_pc4;
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked
// against a transaction-level model of the expected instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        NextPCSrc;
  logic [31:0] BranchTarget;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [31:0] fetch_count;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .NextPCSrc(NextPCSrc),
    .BranchTarget(BranchTarget),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_pc4(inst_pc4),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory contents: explicit overrides, otherwise an address hash
  logic [31:0] mem [logic [31:0]];

  // environment knobs
  int rdy_pct = 100;
  int dec_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  int redir_pct = 0;
  logic        redir_req = 1'b0;
  logic [31:0] redir_tgt = '0;

  // memory responder state
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // reference model: pc of the next correct-path instruction
  logic [31:0] seq_pc = RST_PC;
  int          nfire = 0;
  logic [31:0] last_pc4 = '0;
  logic [31:0] acc_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] first_acc();
    if (acc_q.size() == 0) return 32'hxxxx_xxxx;
    return acc_q[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive inputs, check against model, advance
  task automatic cyc();
    logic acc, fire, pv, iv;
    logic [31:0] a, pi;
    if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      redir_req = 1'b1;
      redir_tgt = $urandom;
    end
    NextPCSrc      = redir_req;
    BranchTarget   = redir_tgt;
    imem_rsp_valid = pend && pend_cnt == 1;
    imem_rsp_data  = imem_rsp_valid ? memfn(pend_addr) : $urandom;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    inst_ready     = $urandom_range(99) < dec_pct;
    #1;
    acc  = imem_req_valid && imem_req_ready;
    fire = inst_valid && inst_ready && !NextPCSrc;
    a    = imem_addr;
    pi   = inst;
    chk("req_while_hold", 32'(imem_req_valid & inst_valid), 32'd0);
    if (acc) begin
      chk("req_addr", a, seq_pc);
      chk("one_outstanding", 32'(pend), 32'd0);
      acc_q.push_back(a);
    end
    if (fire) begin
      chk("inst_pc", inst_pc, seq_pc);
      chk("inst_pc4", inst_pc4, seq_pc + 32'd4);
      chk("inst", inst, memfn(seq_pc));
      chk("count_at_fire", fetch_count, 32'(nfire));
      last_pc4 = inst_pc4;
      seq_pc   = seq_pc + 32'd4;
      nfire++;
    end
    if (NextPCSrc) seq_pc = BranchTarget & ~32'd3;
    pv = imem_req_valid && !acc && !NextPCSrc;
    iv = inst_valid && !fire && !NextPCSrc;
    if (imem_rsp_valid) pend = 1'b0;
    else if (pend) pend_cnt--;
    @(posedge clk);
    #1;
    redir_req = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = $urandom_range(lat_max, lat_min);
      pend_addr = a;
    end
    if (pv) begin
      chk("addr_stable", imem_addr, a);
      chk("req_stable", 32'(imem_req_valid), 32'd1);
    end
    if (iv) begin
      chk("inst_stable", inst, pi);
      chk("ivalid_stable", 32'(inst_valid), 32'd1);
    end
  endtask

  initial begin
    int n0, b;
    logic saw;
    rst = 1'b1;
    NextPCSrc = 1'b0;
    BranchTarget = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc4", inst_pc4, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    rst = 1'b0;
    #1;
    chk("first_cycle_novalid", 32'(imem_req_valid), 32'd0);

    // straight-line fetch, 1-cycle memory, decode always ready
    b = 0;
    while (nfire < 3 && b < 40) begin cyc(); b++; end
    chk("seq_done", 32'(nfire), 32'd3);
    chk("seq_count", fetch_count, 32'd3);
    chk("seq_addr1", (acc_q.size() > 1) ? acc_q[1] : 32'hx, 32'h4);
    chk("seq_addr2", (acc_q.size() > 2) ? acc_q[2] : 32'hx, 32'h8);

    // decode stall in HOLD
    mem[seq_pc] = 32'h0050_0093;
    dec_pct = 0;
    b = 0;
    while (!inst_valid && b < 10) begin cyc(); b++; end
    chk("stall_reach", 32'(inst_valid), 32'd1);
    repeat (5) begin
      cyc();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0050_0093);
      chk("stall_noreq", 32'(imem_req_valid), 32'd0);
      chk("stall_count", fetch_count, 32'd3);
    end
    dec_pct = 100;
    cyc();
    chk("stall_release", fetch_count, 32'd4);

    // redirect while waiting; wrong-path response arrives later
    lat_min = 3;
    lat_max = 3;
    b = 0;
    while (!pend && b < 10) begin cyc(); b++; end
    chk("wait_reach", 32'(pend), 32'd1);
    mem[pend_addr] = 32'hDEAD_BEEF;
    redir_req = 1'b1;
    redir_tgt = 32'h100;
    lat_min = 1;
    lat_max = 1;
    acc_q.delete();
    saw = 1'b0;
    n0 = nfire;
    b = 0;
    while (nfire < n0 + 1 && b < 20) begin
      cyc();
      if (inst_valid && inst === 32'hDEAD_BEEF) saw = 1'b1;
      b++;
    end
    chk("no_wrong_path", 32'(saw), 32'd0);
    chk("redir_wait_addr", first_acc(), 32'h100);
    chk("redir_wait_fire", 32'(nfire), 32'(n0 + 1));

    // redirect in HOLD with decode ready: no fire
    b = 0;
    while (!inst_valid && b < 10) begin cyc(); b++; end
    n0 = nfire;
    redir_req = 1'b1;
    redir_tgt = 32'h203;
    acc_q.delete();
    cyc();
    chk("hold_redir_ivalid", 32'(inst_valid), 32'd0);
    chk("hold_redir_count", fetch_count, 32'(n0));
    b = 0;
    while (acc_q.size() == 0 && b < 10) begin cyc(); b++; end
    chk("hold_redir_addr", first_acc(), 32'h200);

    // pc wrap at the top of the address space
    b = 0;
    while (!inst_valid && b < 10) begin cyc(); b++; end
    redir_req = 1'b1;
    redir_tgt = 32'hFFFF_FFFF;
    cyc();
    n0 = nfire;
    b = 0;
    while (nfire < n0 + 1 && b < 20) begin cyc(); b++; end
    chk("wrap_pc4", last_pc4, 32'h0);
    acc_q.delete();
    b = 0;
    while (acc_q.size() == 0 && b < 10) begin cyc(); b++; end
    chk("wrap_addr", first_acc(), 32'h0);

    // reset during WAIT with the response landing inside reset
    lat_min = 2;
    lat_max = 2;
    b = 0;
    while (!pend && b < 10) begin cyc(); b++; end
    rst = 1'b1;
    NextPCSrc = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_inst_pc", inst_pc, 32'd0);
    chk("mid_rst_inst_pc4", inst_pc4, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seq_pc = RST_PC;
    nfire = 0;
    lat_min = 1;
    lat_max = 1;
    // a stale response shows up right after release
    mem[32'h40] = 32'hDEAD_BEEF;
    pend = 1'b1;
    pend_cnt = 1;
    pend_addr = 32'h40;
    acc_q.delete();
    b = 0;
    while (nfire < 1 && b < 20) begin cyc(); b++; end
    chk("post_rst_addr", first_acc(), RST_PC);
    chk("post_rst_count", fetch_count, 32'd1);

    // random traffic against the model
    rdy_pct = 70;
    dec_pct = 70;
    lat_min = 1;
    lat_max = 3;
    redir_pct = 6;
    n0 = nfire;
    repeat (3000) cyc();
    chk("progress", 32'((nfire - n0) > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
